// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

  // Number of requesters sharing the data memory.
  localparam int NUM_REQ = 2;

  // Arbiter FSM states; IDLE is the reset state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Requester identifier (0 or 1).
  typedef logic req_id_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for the memory arbiter.
// Policy is chosen at compile time by MEM_ARB_ROUND_ROBIN_EN:
//   defined   -> on a tie, the requester that did not win last time wins
//   undefined -> fixed priority, requester 0 always wins a tie
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            last_winner,
  output req_id_t            winner,
  output logic               valid
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // The pointer only matters for round-robin; keep it tied off cleanly here.
  logic unused_last_winner;
  assign unused_last_winner = last_winner;
`endif

  // Decide the winner among the active requests.
  always_comb begin
    valid  = |req;
    winner = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (req == 2'b11) begin
      winner = ~last_winner;
    end else begin
      winner = req[1];
    end
`else
    winner = req[1] & ~req[0];
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory.
// Each transaction takes IDLE -> ACCESS -> DONE: the winner's request is
// latched in IDLE, the memory is strobed in ACCESS, and done pulses in DONE.
// Compile-time option: MEM_ARB_ROUND_ROBIN_EN (round-robin on ties; otherwise
// requester 0 has fixed priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int DATA_DIR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [DATA_DIR_WIDTH-1:0] addr0,
  input  logic [DATA_DIR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]     wdata0,
  input  logic [DATA_WIDTH-1:0]     wdata1,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      busy,
  output logic                      MemWrite,
  output logic                      MemRead,
  output logic [DATA_DIR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0]     WriteData,
  input  logic [DATA_WIDTH-1:0]     ReadData
);

  state_t                    state_q, state_d;
  req_id_t                   winner_q, winner_d;
  req_id_t                   last_q, last_d;
  logic                      we_q, we_d;
  logic [DATA_DIR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;

  req_id_t pick_winner;
  logic    pick_valid;

  mem_arb_pick u_pick (
    .req         (req),
    .last_winner (last_q),
    .winner      (pick_winner),
    .valid       (pick_valid)
  );

  // Next-state, transaction latch and memory strobes.
  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    Address   = '0;
    WriteData = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          winner_d = pick_winner;
          we_d     = we[pick_winner];
          addr_d   = pick_winner ? addr1 : addr0;
          wdata_d  = pick_winner ? wdata1 : wdata0;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        Address   = addr_q;
        WriteData = wdata_q;
        MemWrite  = we_q;
        MemRead   = ~we_q;
        // Only reads update rdata; a write leaves the last read value intact.
        if (!we_q) begin
          rdata_d = ReadData;
        end
        state_d = DONE;
      end
      DONE: begin
        last_d  = winner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      winner_q <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // One-cycle completion pulse on the winner's bit only.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_done
    assign done[gi] = (state_q == DONE) && (winner_q == req_id_t'(gi));
  end

  assign busy  = (state_q != IDLE);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model. Honours MEM_ARB_ROUND_ROBIN_EN like the design.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = '0;
  logic [1:0] we = '0;
  logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [1:0] done;
  logic [7:0] rdata, Address, WriteData, ReadData;
  logic       busy, MemWrite, MemRead;

  int total = 0;
  int bad = 0;

  logic [7:0] mem     [0:255];
  logic [7:0] ref_mem [0:255];

  mem_arbiter #(.DATA_WIDTH(8), .DATA_DIR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done(done), .rdata(rdata), .busy(busy),
    .MemWrite(MemWrite), .MemRead(MemRead), .Address(Address),
    .WriteData(WriteData), .ReadData(ReadData)
  );

  always #5 clk = ~clk;

  // Environment memory: combinational read, write on the clock edge.
  assign ReadData = mem[Address];
  always @(posedge clk) if (MemWrite) mem[Address] = WriteData;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // ---------------- transaction-level reference model ----------------
  int         m_phase = 0;        // 0 free, 1 memory cycle, 2 completion cycle
  logic       m_win = 1'b0, m_we = 1'b0, m_last = 1'b1;
  logic [7:0] m_addr = '0, m_wdata = '0, m_rdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_last  = 1'b1;
      m_rdata = '0;
    end else begin
      case (m_phase)
        0: if (req != 2'b00) begin
          if (req == 2'b01)      m_win = 1'b0;
          else if (req == 2'b10) m_win = 1'b1;
          else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            m_win = ~m_last;
`else
            m_win = 1'b0;
`endif
          end
          m_we    = we[m_win];
          m_addr  = m_win ? addr1 : addr0;
          m_wdata = m_win ? wdata1 : wdata0;
          m_phase = 1;
        end
        1: begin
          if (m_we) ref_mem[m_addr] = m_wdata;
          else      m_rdata = ref_mem[m_addr];
          m_phase = 2;
        end
        default: begin
          m_last  = m_win;
          m_phase = 0;
        end
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("busy",      busy,      m_phase != 0);
    chk("MemRead",   MemRead,   (m_phase == 1) && !m_we);
    chk("MemWrite",  MemWrite,  (m_phase == 1) && m_we);
    chk("Address",   Address,   (m_phase == 1) ? m_addr : 8'h00);
    chk("WriteData", WriteData, (m_phase == 1) ? m_wdata : 8'h00);
    chk("done",      done,      (m_phase == 2) ? (2'b01 << m_win) : 2'b00);
    chk("rdata",     rdata,     m_rdata);
  end

  // Wait (bounded) for a done pulse; report strobe activity seen on the way.
  task automatic wait_done(output logic [1:0] d, output int n_rd, output int n_wr,
                           output logic [7:0] a, output logic [7:0] wd);
    d = 2'b00; n_rd = 0; n_wr = 0; a = '0; wd = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (MemRead)  begin n_rd++; a = Address; end
      if (MemWrite) begin n_wr++; a = Address; wd = WriteData; end
      if (done != 2'b00) begin
        d = done;
        break;
      end
    end
    if (d == 2'b00) timeout("wait_done");
  endtask

  task automatic wait_access(output logic seen);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (MemRead || MemWrite) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) timeout("wait_access");
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [1:0] d;
  logic [1:0] order [0:2];
  logic [1:0] exp_order [0:2];
  logic [7:0] a, wd, prev;
  int         n_rd, n_wr;
  logic       seen;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i * 7 + 1);
      ref_mem[i] = 8'(i * 7 + 1);
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01;
`else
    exp_order[0] = 2'b01; exp_order[1] = 2'b01; exp_order[2] = 2'b01;
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 2'b00);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_strobes", {MemRead, MemWrite}, 2'b00);
    @(posedge clk); #1 rst_n = 1'b1;

    // Read of address 0 by requester 0.
    req = 2'b01; we = 2'b00; addr0 = 8'h00;
    wait_done(d, n_rd, n_wr, a, wd);
    $display("txn read0: done=%b rdata=%h", d, rdata);
    chk("t1_done", d, 2'b01);
    chk("t1_nread", n_rd, 1);
    chk("t1_addr", a, 8'h00);
    chk("t1_rdata", rdata, 8'h01);
    @(posedge clk); #1 req = 2'b00;

    // Write 0xA5 to address 3 by requester 1.
    @(posedge clk); #1;
    prev = rdata;
    req = 2'b10; we = 2'b10; addr1 = 8'h03; wdata1 = 8'hA5;
    wait_done(d, n_rd, n_wr, a, wd);
    $display("txn write1: done=%b addr=%h wdata=%h", d, a, wd);
    chk("t2_done", d, 2'b10);
    chk("t2_nwrite", n_wr, 1);
    chk("t2_nread", n_rd, 0);
    chk("t2_addr", a, 8'h03);
    chk("t2_wdata", wd, 8'hA5);
    chk("t2_rdata_hold", rdata, prev);
    @(posedge clk); #1 req = 2'b00; we = 2'b00;

    // Read back address 3.
    @(posedge clk); #1;
    req = 2'b01; addr0 = 8'h03;
    wait_done(d, n_rd, n_wr, a, wd);
    $display("txn readback: done=%b rdata=%h", d, rdata);
    chk("t3_done", d, 2'b01);
    chk("t3_rdata", rdata, 8'hA5);
    @(posedge clk); #1 req = 2'b00;

    // Simultaneous requests held across three transactions, from fresh reset.
    do_reset();
    req = 2'b11; we = 2'b00; addr0 = 8'h04; addr1 = 8'h05;
    for (int t = 0; t < 3; t++) begin
      wait_done(d, n_rd, n_wr, a, wd);
      order[t] = d;
      $display("txn tie %0d: done=%b rdata=%h", t, d, rdata);
      chk("t4_order", d, exp_order[t]);
      chk("t4_rdata", rdata, (d == 2'b10) ? 8'h24 : 8'h1D);
    end
    @(posedge clk); #1 req = 2'b00;

    // Reset pulsed during ACCESS aborts the transaction.
    @(posedge clk); #1;
    req = 2'b01; addr0 = 8'h06;
    wait_access(seen);
    #1 rst_n = 1'b0;
    #1;
    $display("txn abort: MemRead=%b busy=%b done=%b", MemRead, busy, done);
    chk("t5_memread", MemRead, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_addr", Address, 8'h00);
    chk("t5_done", done, 2'b00);
    req = 2'b00;
    @(posedge clk); #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_no_done", done, 2'b00);
      chk("t5_idle", busy, 1'b0);
    end

    // Request dropped mid-ACCESS still completes.
    @(posedge clk); #1;
    req = 2'b01; addr0 = 8'h02;
    wait_access(seen);
    #1 req = 2'b00;
    wait_done(d, n_rd, n_wr, a, wd);
    $display("txn drop: done=%b rdata=%h", d, rdata);
    chk("t6_done", d, 2'b01);
    chk("t6_rdata", rdata, 8'h0F);
    repeat (2) begin
      @(negedge clk);
      chk("t6_idle", busy, 1'b0);
    end

    // Randomized traffic, including occasional asynchronous resets.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      req    = 2'($urandom_range(0, 3));
      we     = 2'($urandom_range(0, 3));
      addr0  = 8'($urandom_range(0, 15));
      addr1  = 8'($urandom_range(0, 15));
      wdata0 = 8'($urandom);
      wdata1 = 8'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        #3 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, memory data word width.
REQ-002 Parameter DATA_DIR_WIDTH, default 8, memory address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  2  per-requester access request, bit i = requester i.
REQ-006 we  input  2  per-requester write enable (1 = write, 0 = read).
REQ-007 addr0, addr1  input  DATA_DIR_WIDTH each  per-requester address.
REQ-008 wdata0, wdata1  input  DATA_WIDTH each  per-requester write data.
REQ-009 done  output  2  one-cycle completion pulse, bit i = requester i.
REQ-010 rdata  output  DATA_WIDTH  registered read data, valid while done is nonzero.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 MemWrite, MemRead  output  1 each  data-memory strobes.
REQ-013 Address  output  DATA_DIR_WIDTH  data-memory address.
REQ-014 WriteData  output  DATA_WIDTH  data-memory write data.
REQ-015 ReadData  input  DATA_WIDTH  data-memory combinational read data.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS and DONE, with IDLE as the reset state.
REQ-017 In IDLE with req nonzero: pick the winner per REQ-023, latch the winner id, we, addr and wdata into internal registers, and go to ACCESS; with req zero, stay in IDLE.
REQ-018 In ACCESS: drive Address/WriteData from the latched values, assert MemWrite if the latched we=1, else assert MemRead; capture ReadData into rdata on the clock edge leaving ACCESS (reads only); go to DONE.
REQ-019 MemWrite and MemRead SHALL be 0 in every state except ACCESS, are never high together, and Address/WriteData SHALL be 0 outside ACCESS.
REQ-020 In DONE: done[winner]=1 and all other done bits 0; update the last-winner pointer to the winner; go to IDLE.
REQ-021 Latency: the access occurs 1 cycle after req is sampled in IDLE, done follows 1 cycle later, giving a peak of one access per 3 cycles.
REQ-022 Handshake: a requester SHALL hold req/we/addr/wdata until done and drop req on the edge after done; a req still high in the following IDLE cycle is treated as a new request.
REQ-023 Arbitration: a single request wins immediately; for simultaneous requests, the winner is chosen per REQ-031/REQ-032.
REQ-024 If req is dropped during ACCESS or DONE, the latched transaction SHALL still complete and still pulse done.
REQ-025 After a write, rdata SHALL hold its previous value and SHALL NOT change.
REQ-026 Inputs of the non-winning requester are ignored until the next IDLE cycle.

Reset
REQ-027 Assertion of rst_n=0 SHALL immediately force state IDLE, done=0, rdata=0, busy=0, MemWrite=MemRead=0, Address=0, WriteData=0, and the last-winner pointer to requester 1 (so requester 0 wins first).
REQ-028 Reset during ACCESS or DONE SHALL abort the transaction with no done pulse; after release, the first IDLE cycle re-arbitrates from scratch.

Configuration
REQ-029 Macro MEM_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy at compile time.
REQ-030 The interface and timing SHALL be identical with and without MEM_ARB_ROUND_ROBIN_EN.
REQ-031 MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, the requester that is not the last winner wins.
REQ-032 MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins; the pointer is still maintained but unused.

Structure
REQ-033 Package mem_arb_pkg SHALL hold the FSM state type (IDLE/ACCESS/DONE), a 1-bit requester-id type, and the requester-count constant 2.
REQ-034 Sub-module mem_arb_pick (combinational: req and last-winner in, winner id and valid out) SHALL contain the policy selection; the FSM and datapath registers stay in mem_arbiter.

Verification
REQ-035 Reset, then req=01, we=00, addr0=0x00 with memory[0]=1 -> MemRead=1 with Address=0x00 in ACCESS, then done=01 and rdata=0x01 in the next cycle.
REQ-036 req=10, we=10, addr1=0x03, wdata1=0xA5 -> MemWrite=1 for exactly 1 cycle with Address=0x03 and WriteData=0xA5, then done=10 and rdata unchanged; a following read of 0x03 returns 0xA5.
REQ-037 req=11 held for three transactions -> with MEM_ARB_ROUND_ROBIN_EN, done order is 01,10,01; without it, done order is 01,01,01.
REQ-038 req=01 with rst_n pulsed low during ACCESS -> strobes drop to 0 asynchronously, no done pulse, and state returns to IDLE.
REQ-039 req0 dropped during ACCESS -> done=01 still pulses with correct rdata; the next IDLE cycle with req=00 stays IDLE and busy=0.
